// File: rtl/rom_scanner.sv
// Sequential ROM reader: walks len words from base (wrapping), presents each word
// on a valid/ready output and accumulates a mod-2^DW checksum of accepted words.
//
// state | meaning
// IDLE  | waiting for start with nonzero len
// FETCH | ROM enabled for one cycle, word captured at the closing edge
// HOLD  | word offered downstream until accepted or aborted
// DONE  | one-cycle done pulse, then back to IDLE
module rom_scanner #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base,
   input  logic [AW:0]   len,
   input  logic          abort,
   output logic [AW-1:0] rom_addr,
   output logic          rom_en,
   output logic          rom_ce,
   input  logic [DW-1:0] rom_data,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] checksum
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

   state_t        state, state_n;
   logic [AW:0]   remaining, remaining_n;
   logic [AW-1:0] rom_addr_n;
   logic          rom_en_n, rom_ce_n;
   logic [DW-1:0] out_data_n, checksum_n;
   logic          out_valid_n, out_last_n, busy_n, done_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         remaining <= '0;
         rom_addr  <= '0;
         rom_en    <= 1'b0;
         rom_ce    <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         checksum  <= '0;
      end else begin
         state     <= state_n;
         remaining <= remaining_n;
         rom_addr  <= rom_addr_n;
         rom_en    <= rom_en_n;
         rom_ce    <= rom_ce_n;
         out_data  <= out_data_n;
         out_valid <= out_valid_n;
         out_last  <= out_last_n;
         busy      <= busy_n;
         done      <= done_n;
         checksum  <= checksum_n;
      end
   end

   // Outputs are computed one cycle ahead so every port comes straight from a flop.
   always_comb begin
      state_n     = state;
      remaining_n = remaining;
      rom_addr_n  = rom_addr;
      rom_en_n    = 1'b0;
      rom_ce_n    = 1'b0;
      out_data_n  = out_data;
      out_valid_n = out_valid;
      out_last_n  = out_last;
      busy_n      = busy;
      done_n      = 1'b0;
      checksum_n  = checksum;
      case (state)
         IDLE: begin
            if (start && (len != '0)) begin
               state_n     = FETCH;
               rom_addr_n  = base;
               remaining_n = (len > DEPTH) ? DEPTH : len;
               checksum_n  = '0;
               rom_en_n    = 1'b1;
               rom_ce_n    = 1'b1;
               busy_n      = 1'b1;
            end
         end
         FETCH: begin
            if (abort) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end else begin
               state_n     = HOLD;
               out_data_n  = rom_data;
               out_valid_n = 1'b1;
               out_last_n  = (remaining == ONE);
            end
         end
         HOLD: begin
            if (abort) begin
               state_n     = IDLE;
               out_valid_n = 1'b0;
               out_last_n  = 1'b0;
               busy_n      = 1'b0;
            end else if (out_ready) begin
               checksum_n  = checksum + out_data;
               remaining_n = remaining - ONE;
               out_valid_n = 1'b0;
               out_last_n  = 1'b0;
               if (remaining == ONE) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end else begin
                  state_n    = FETCH;
                  rom_addr_n = rom_addr + AW'(1);
                  rom_en_n   = 1'b1;
                  rom_ce_n   = 1'b1;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_rom_scanner.sv
// Randomized bench for rom_scanner: a queue of expected words per scan, derived
// from base/len with modular addressing, is compared against the output stream.
module tb_rom_scanner;

   logic       clk = 1'b0;
   logic       rst_n, start, abort, out_ready;
   logic [3:0] base;
   logic [4:0] len;
   logic [3:0] rom_addr;
   logic       rom_en, rom_ce;
   logic [7:0] rom_data, out_data, checksum;
   logic       out_valid, out_last, busy, done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] rom [16] = '{8'h0a, 8'h37, 8'hf4, 8'h00, 8'h09, 8'hff, 8'h11, 8'h01,
                            8'h10, 8'h15, 8'h1d, 8'h25, 8'h60, 8'h90, 8'h70, 8'h91};

   assign rom_data = (rom_en && rom_ce) ? rom[rom_addr] : 8'hzz;

   always #5 clk = ~clk;

   rom_scanner #(.AW(4), .DW(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len), .abort(abort),
      .rom_addr(rom_addr), .rom_en(rom_en), .rom_ce(rom_ce), .rom_data(rom_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done), .checksum(checksum)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One scan against the model; abort_at >= 0 aborts once that many words are accepted.
   task automatic scan(input logic [3:0] b, input logic [4:0] l, input int rdy_pct,
                       input int abort_at, input bit extra_start);
      logic [7:0] exp_q[$];
      logic [7:0] sum, prev_d;
      logic       prev_l;
      int         n, idx, cyc;
      bit         xfer, stall, fin;
      n = (l > 5'd16) ? 16 : int'(l);
      for (int i = 0; i < n; i++) exp_q.push_back(rom[(int'(b) + i) % 16]);
      @(negedge clk);
      base = b; len = l; start = 1'b1; abort = 1'b0;
      out_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      start = 1'b0;
      if (n == 0) begin
         repeat (4) begin
            chk("len0_busy", busy, 0);
            chk("len0_rom_en", {rom_en, rom_ce}, 0);
            @(negedge clk);
         end
         return;
      end
      chk("lat_fetch", {rom_en, rom_ce, busy, out_valid}, 4'b1110);
      chk("lat_addr", rom_addr, b);
      chk("sum_clear", checksum, 0);
      idx = 0; cyc = 0; sum = 8'h00; stall = 1'b0; fin = 1'b0;
      prev_d = 8'h00; prev_l = 1'b0;
      while (!fin && cyc < 400) begin
         if (out_valid) begin
            if (idx < n) chk("data", out_data, exp_q[idx]);
            else chk("extra_word", idx, n - 1);
            chk("last", out_last, (idx == n - 1));
            chk("rom_off_hold", {rom_en, rom_ce}, 0);
            if (stall) chk("stable", {out_last, out_data}, {prev_l, prev_d});
         end else begin
            chk("last_no_valid", out_last, 0);
         end
         if (done) begin
            start = 1'b0;
            chk("done_words", idx, n);
            chk("checksum", checksum, sum);
            if (rdy_pct >= 100) chk("throughput", cyc, 2 * n);
            fin = 1'b1;
         end else if (abort_at >= 0 && idx == abort_at) begin
            start = 1'b0;
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_idle", {busy, out_valid, out_last, rom_en, rom_ce}, 0);
            chk("abort_sum", checksum, sum);
            repeat (3) begin
               chk("abort_no_done", {done, busy}, 0);
               @(negedge clk);
            end
            return;
         end else begin
            out_ready = ($urandom_range(99) < rdy_pct);
            start = extra_start && ($urandom_range(3) == 0);
            if (start) begin
               base = 4'($urandom);
               len  = 5'($urandom);
            end
            xfer   = out_valid && out_ready;
            stall  = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
            @(negedge clk);
            if (xfer) begin
               if (idx < n) sum = sum + exp_q[idx];
               idx++;
            end
            cyc++;
         end
      end
      chk("done_seen", fin, 1);
      @(negedge clk);
      chk("post_idle", {busy, done, rom_en}, 0);
      chk("sum_hold", checksum, sum);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      base = 4'd0; len = 5'd0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {rom_addr, rom_en, rom_ce, out_data, out_valid, out_last,
                            busy, done, checksum}, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("no_scan_after_reset", busy, 0);

      scan(4'd0,  5'd3,  100, -1, 1'b0);
      scan(4'd14, 5'd3,  100, -1, 1'b0);
      scan(4'd0,  5'd16, 50,  -1, 1'b1);
      abort = 1'b1;
      scan(4'd2,  5'd0,  100, -1, 1'b0);
      scan(4'd3,  5'd20, 100, -1, 1'b0);
      scan(4'd5,  5'd8,  100, 2,  1'b0);
      for (int r = 0; r < 8; r++)
         scan(4'($urandom), 5'($urandom_range(1, 20)), $urandom_range(30, 100),
              ($urandom_range(3) == 0) ? $urandom_range(0, 3) : -1, 1'b1);

      @(negedge clk);
      base = 4'd0; len = 5'd16; start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {rom_addr, rom_en, rom_ce, out_data, out_valid, out_last,
                             busy, done, checksum}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("idle_after_reset", {busy, rom_en, rom_ce, out_valid}, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
